rpt_sched: RTL and testbench

Report scheduler between the 50 MHz-domain measurement outputs (four 30-bit PPS phase words, 28-bit reference frequency count) and the UART byte transmitter. On each measurement-valid strobe it snapshots the results. It then sequences a framed binary report, one byte at a time, over a valid/ready handshake. A one-deep pending buffer absorbs a strobe that arrives mid-frame; further strobes are dropped and counted.

---
 rtl/rpt_sched.sv | 210 +++++++++++++++++++++
 tb/tb_rpt_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpt_sched.sv
// rpt_sched: snapshots measurement results and streams them as a framed byte report.
// Build option: define RPT_CKSUM_EN to append the XOR checksum byte to every frame.
module rpt_sched (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ph_en,
    input  logic [29:0] i_ph1,
    input  logic [29:0] i_ph2,
    input  logic [29:0] i_ph3,
    input  logic [29:0] i_ph4,
    input  logic [27:0] i_freq,
    input  logic [3:0]  i_ch_mask,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_pend,
    output logic [7:0]  o_seq,
    output logic [7:0]  o_drop_cnt
);

    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [2:0] {
        StIdle, StSync, StSeq, StMask, StPh, StFreq, StCksum
    } state_e;

    typedef struct packed {
        logic [3:0][29:0] ph;
        logic [27:0]      freq;
        logic [3:0]       mask;
    } snap_t;

    state_e     state_q, state_d;
    snap_t      act_q, act_d, pend_q, pend_d, in_snap;
    logic       pend_vld_q, pend_vld_d;
    logic       valid_q, valid_d;
    logic [1:0] ch_q, ch_d, bi_q, bi_d;
    logic [7:0] seq_q, seq_d, nseq_q, nseq_d;
    logic [7:0] csum_q, csum_d, drop_q, drop_d, data_q, data_d;
    logic       xfer, last, start;
    logic [2:0] nxt_ch;

    // Lowest enabled channel at or above 'from'; 4 means none left.
    function automatic logic [2:0] find_ch(input logic [3:0] mask, input logic [2:0] from);
        find_ch = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) find_ch = 3'(i);
        end
    endfunction

    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] b);
        unique case (b)
            2'd0:    pick = w[31:24];
            2'd1:    pick = w[23:16];
            2'd2:    pick = w[15:8];
            default: pick = w[7:0];
        endcase
    endfunction

    always_comb begin
        in_snap.ph   = {i_ph4, i_ph3, i_ph2, i_ph1};
        in_snap.freq = i_freq;
        in_snap.mask = i_ch_mask;
    end

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        valid_d    = valid_q;
        ch_d       = ch_q;
        bi_d       = bi_q;
        seq_d      = seq_q;
        nseq_d     = nseq_q;
        csum_d     = csum_q;
        drop_d     = drop_q;
        data_d     = 8'h00;
        xfer       = valid_q & i_tx_ready;
        last       = 1'b0;
        start      = 1'b0;
        nxt_ch     = 3'd4;

        if (xfer) begin
            unique case (state_q)
                StSync: state_d = StSeq;
                StSeq: begin
                    csum_d  = csum_q ^ data_q;
                    state_d = StMask;
                end
                StMask: begin
                    csum_d = csum_q ^ data_q;
                    nxt_ch = find_ch(act_q.mask, 3'd0);
                    bi_d   = 2'd0;
                    if (nxt_ch[2]) begin
                        state_d = StFreq;
                    end else begin
                        state_d = StPh;
                        ch_d    = nxt_ch[1:0];
                    end
                end
                StPh: begin
                    csum_d = csum_q ^ data_q;
                    bi_d   = bi_q + 2'd1;
                    if (bi_q == 2'd3) begin
                        nxt_ch = find_ch(act_q.mask, {1'b0, ch_q} + 3'd1);
                        if (nxt_ch[2]) state_d = StFreq;
                        else           ch_d    = nxt_ch[1:0];
                    end
                end
                StFreq: begin
                    csum_d = csum_q ^ data_q;
                    bi_d   = bi_q + 2'd1;
                    if (bi_q == 2'd3) begin
`ifdef RPT_CKSUM_EN
                        state_d = StCksum;
`else
                        last = 1'b1;
`endif
                    end
                end
                StCksum: last = 1'b1;
                default: ;
            endcase
        end

        // Pending always wins the next slot; a coincident strobe then refills pending.
        if (state_q == StIdle || last) begin
            if (pend_vld_q) begin
                act_d      = pend_q;
                start      = 1'b1;
                pend_vld_d = i_ph_en;
                if (i_ph_en) pend_d = in_snap;
            end else if (i_ph_en) begin
                act_d = in_snap;
                start = 1'b1;
            end
        end else if (i_ph_en) begin
            if (!pend_vld_q) begin
                pend_d     = in_snap;
                pend_vld_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        if (start) begin
            state_d = StSync;
            valid_d = 1'b1;
            seq_d   = nseq_q;
            nseq_d  = nseq_q + 8'd1;
            csum_d  = 8'h00;
            ch_d    = 2'd0;
            bi_d    = 2'd0;
        end else if (last) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end

        // Output byte is registered, so it is derived from the next-state view.
        unique case (state_d)
            StSync:  data_d = SyncByte;
            StSeq:   data_d = seq_d;
            StMask:  data_d = {4'b0, act_d.mask};
            StPh:    data_d = pick({2'b0, act_d.ph[ch_d]}, bi_d);
            StFreq:  data_d = pick({4'b0, act_d.freq}, bi_d);
            StCksum: data_d = csum_d;
            default: data_d = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            ch_q       <= 2'd0;
            bi_q       <= 2'd0;
            seq_q      <= 8'h00;
            nseq_q     <= 8'h00;
            csum_q     <= 8'h00;
            drop_q     <= 8'h00;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            valid_q    <= valid_d;
            ch_q       <= ch_d;
            bi_q       <= bi_d;
            seq_q      <= seq_d;
            nseq_q     <= nseq_d;
            csum_q     <= csum_d;
            drop_q     <= drop_d;
            data_q     <= data_d;
        end
    end

    assign o_tx_data  = data_q;
    assign o_tx_valid = valid_q;
    assign o_busy     = valid_q;
    assign o_pend     = pend_vld_q;
    assign o_seq      = seq_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_rpt_sched.sv
// Directed self-checking bench for rpt_sched; frame length follows RPT_CKSUM_EN.
module tb_rpt_sched;

`ifdef RPT_CKSUM_EN
    localparam int CksLen = 1;
`else
    localparam int CksLen = 0;
`endif
    localparam int FullLen = 23 + CksLen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ph_en = 1'b0;
    logic [29:0] ph1 = '0, ph2 = '0, ph3 = '0, ph4 = '0;
    logic [27:0] freq = '0;
    logic [3:0]  mask = '0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, pend;
    logic [7:0]  seq, drop_cnt;

    int errors = 0;
    int checks = 0;
    int hold_viol;
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    logic [7:0] exp_q[$];

    rpt_sched dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ph_en    (ph_en),
        .i_ph1      (ph1),
        .i_ph2      (ph2),
        .i_ph3      (ph3),
        .i_ph4      (ph4),
        .i_freq     (freq),
        .i_ch_mask  (mask),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_pend     (pend),
        .o_seq      (seq),
        .o_drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; ph_en = 1'b0; tx_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_snap(input logic [29:0] a, b, c, d, input logic [27:0] f,
                            input logic [3:0] m);
        ph1 = a; ph2 = b; ph3 = c; ph4 = d; freq = f; mask = m;
    endtask

    // Called at a negedge; returns at the negedge after the strobe edge.
    task automatic strobe(input logic [29:0] a, b, c, d, input logic [27:0] f,
                          input logic [3:0] m);
        set_snap(a, b, c, d, f, m);
        ph_en = 1'b1;
        @(negedge clk);
        ph_en = 1'b0;
    endtask

    // Reference frame model.
    task automatic build_exp(input logic [7:0] s, input logic [3:0] m, input logic [29:0] p1,
                             p2, p3, p4, input logic [27:0] f);
        logic [29:0] p[4];
        logic [31:0] w;
        logic [7:0]  ck;
        p[0] = p1; p[1] = p2; p[2] = p3; p[3] = p4;
        exp_q = {};
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        exp_q.push_back({4'b0, m});
        ck = s ^ {4'b0, m};
        for (int n = 0; n < 4; n++) begin
            if (m[n]) begin
                w = {2'b0, p[n]};
                for (int b = 3; b >= 0; b--) begin
                    exp_q.push_back(w[b*8 +: 8]);
                    ck = ck ^ w[b*8 +: 8];
                end
            end
        end
        w = {4'b0, f};
        for (int b = 3; b >= 0; b--) begin
            exp_q.push_back(w[b*8 +: 8]);
            ck = ck ^ w[b*8 +: 8];
        end
        if (CksLen != 0) exp_q.push_back(ck);
    endtask

    // Receives n bytes (mode 0: ready held high, mode 1: random ready); starts and ends at a
    // negedge, ending just after the last transfer edge.
    task automatic collect(input int n, input int mode, input int budget);
        int         c;
        logic [7:0] prev;
        logic       prev_stall;
        c = 0; prev = '0; prev_stall = 1'b0; hold_viol = 0;
        rx_q = {}; rx_cyc = {};
        while (rx_q.size() < n && c < budget) begin
            if (prev_stall && tx_data !== prev) hold_viol++;
            tx_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                rx_cyc.push_back(c);
            end
            prev_stall = tx_valid && !tx_ready;
            prev = tx_data;
            @(negedge clk);
            c++;
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({tx_data, tx_valid, busy, pend, seq, drop_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL reset_vals: data=%h valid=%b busy=%b pend=%b seq=%h drop=%h, want all 0",
                     tx_data, tx_valid, busy, pend, seq, drop_cnt);
        end
        do_reset();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid: got %b want 0", tx_valid);
        end
    endtask

    task automatic test_full_mask();
        int bad;
        do_reset();
        exp_q = {8'hA5, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h05, 8'hF5, 8'hE1,
                 8'h00, 8'h1A};
        if (CksLen == 0) void'(exp_q.pop_back());
        strobe(30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100, 4'hF);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_latency: valid=%b data=%h busy=%b want 1 A5 1",
                     tx_valid, tx_data, busy);
        end
        checks++;
        if (seq !== 8'h00) begin
            errors++; $display("FAIL full_seq: got %h want 00", seq);
        end
        collect(FullLen, 0, 100);
        bad = -1;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0 || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL full_bytes: got %0d bytes (first bad idx %0d), want %0d bytes",
                     rx_q.size(), bad, exp_q.size());
        end
        checks++;
        if (rx_q.size() == FullLen && rx_cyc[FullLen-1] - rx_cyc[0] != FullLen - 1) begin
            errors++;
            $display("FAIL full_rate: span %0d cycles want %0d",
                     rx_cyc[FullLen-1] - rx_cyc[0], FullLen - 1);
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL full_end: valid=%b busy=%b want 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_partial_mask();
        int bad;
        do_reset();
        build_exp(8'h00, 4'h1, 30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100);
        strobe(30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100, 4'h1);
        collect(11 + CksLen, 0, 100);
        bad = -1;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0 || rx_q.size() != 11 + CksLen) begin
            errors++;
            $display("FAIL partial_bytes: got %0d bytes (first bad idx %0d), want %0d",
                     rx_q.size(), bad, 11 + CksLen);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL partial_end: valid=%b want 0", tx_valid);
        end
        // Empty mask, second frame so seq=1.
        build_exp(8'h01, 4'h0, 30'h3FFFFFFF, 30'd7, 30'd8, 30'd9, 28'hABCDEF1);
        strobe(30'h3FFFFFFF, 30'd7, 30'd8, 30'd9, 28'hABCDEF1, 4'h0);
        collect(7 + CksLen, 0, 100);
        bad = -1;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0 || rx_q.size() != 7 + CksLen) begin
            errors++;
            $display("FAIL mask0_bytes: got %0d bytes (first bad idx %0d), want %0d",
                     rx_q.size(), bad, 7 + CksLen);
        end
    endtask

    task automatic test_back_pressure();
        int bad;
        do_reset();
        build_exp(8'h00, 4'hF, 30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100);
        strobe(30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100, 4'hF);
        collect(FullLen, 1, 1000);
        checks++;
        if (hold_viol != 0) begin
            errors++; $display("FAIL bp_hold: %0d data changes while stalled, want 0", hold_viol);
        end
        bad = -1;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0 || rx_q.size() != FullLen) begin
            errors++;
            $display("FAIL bp_bytes: got %0d bytes (first bad idx %0d), want %0d",
                     rx_q.size(), bad, FullLen);
        end
    endtask

    task automatic test_back_to_back();
        int c, bad, len_a;
        logic [7:0] exp_a[$];
        do_reset();
        build_exp(8'h00, 4'hF, 30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100);
        exp_a = exp_q;
        len_a = exp_a.size();
        build_exp(8'h01, 4'hA, 30'h11, 30'h22, 30'h33, 30'h3FFFFFFF, 28'hFFFFFFF);
        for (int i = 0; i < exp_q.size(); i++) exp_a.push_back(exp_q[i]);
        strobe(30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100, 4'hF);
        rx_q = {}; rx_cyc = {}; c = 0; tx_ready = 1'b1;
        while (rx_q.size() < exp_a.size() && c < 200) begin
            if (c == 3) begin
                checks++;
                if (pend !== 1'b1 || drop_cnt !== 8'd0) begin
                    errors++; $display("FAIL ovr_pend: pend=%b drop=%0d want 1 0", pend, drop_cnt);
                end
            end
            if (c == 5) begin
                checks++;
                if (pend !== 1'b1 || drop_cnt !== 8'd1) begin
                    errors++; $display("FAIL ovr_drop: pend=%b drop=%0d want 1 1", pend, drop_cnt);
                end
            end
            if (rx_q.size() == len_a && rx_cyc[len_a-1] == c - 1) begin
                checks++;
                if (pend !== 1'b0 || seq !== 8'h01 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
                    errors++;
                    $display("FAIL b2b_switch: pend=%b seq=%h valid=%b data=%h want 0 01 1 A5",
                             pend, seq, tx_valid, tx_data);
                end
            end
            ph_en = (c == 2 || c == 4);
            if (c == 2) set_snap(30'h11, 30'h22, 30'h33, 30'h3FFFFFFF, 28'hFFFFFFF, 4'hA);
            if (c == 4) set_snap(30'h5, 30'h6, 30'h7, 30'h8, 28'h1234567, 4'h0);
            if (tx_valid) begin
                rx_q.push_back(tx_data);
                rx_cyc.push_back(c);
            end
            @(negedge clk);
            c++;
        end
        tx_ready = 1'b0;
        checks++;
        if (rx_q.size() != exp_a.size()) begin
            errors++; $display("FAIL b2b_count: got %0d bytes want %0d", rx_q.size(), exp_a.size());
        end else begin
            checks++;
            if (rx_cyc[len_a] != rx_cyc[len_a-1] + 1) begin
                errors++;
                $display("FAIL b2b_gap: cycles %0d then %0d, want adjacent",
                         rx_cyc[len_a-1], rx_cyc[len_a]);
            end
        end
        bad = -1;
        for (int i = exp_a.size() - 1; i >= 0; i--)
            if (i >= rx_q.size() || rx_q[i] !== exp_a[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL b2b_bytes: first bad idx %0d of %0d", bad, exp_a.size());
        end
        checks++;
        if (tx_valid !== 1'b0 || pend !== 1'b0) begin
            errors++; $display("FAIL b2b_end: valid=%b pend=%b want 0 0", tx_valid, pend);
        end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        strobe(30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100, 4'hF);
        ph_en = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (pend !== 1'b1 || drop_cnt !== 8'd9) begin
            errors++; $display("FAIL drop_count: pend=%b drop=%0d want 1 9", pend, drop_cnt);
        end
        repeat (250) @(negedge clk);
        ph_en = 1'b0;
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++; $display("FAIL drop_sat: drop=%0d want 255", drop_cnt);
        end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL drop_stall: valid=%b data=%h want 1 A5", tx_valid, tx_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        strobe(30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100, 4'hF);
        collect(FullLen, 0, 100);
        strobe(30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100, 4'hF);
        strobe(30'd9, 30'd9, 30'd9, 30'd9, 28'h9, 4'h3);
        collect(7, 0, 100);
        checks++;
        if (seq !== 8'h01 || pend !== 1'b1 || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_state: seq=%h pend=%b valid=%b want 01 1 1", seq, pend, tx_valid);
        end
        tx_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_valid, busy, pend, seq, drop_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: data=%h valid=%b busy=%b pend=%b seq=%h drop=%h, want 0",
                     tx_data, tx_valid, busy, pend, seq, drop_cnt);
        end
        tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_discard: valid=%b want 0", tx_valid);
        end
        strobe(30'd1, 30'd2, 30'd3, 30'd4, 28'h5F5E100, 4'h6);
        collect(3, 0, 100);
        checks++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h00 || rx_q[2] !== 8'h06) begin
            errors++;
            $display("FAIL post_reset_frame: got %0d bytes, want A5 00 06", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_partial_mask();
        test_back_pressure();
        test_back_to_back();
        test_drop_saturate();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
